alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
//
// PURPOSE
//   Sequential front/back end for the combinational 4-bit ALU (a, b, sel -> y[4:0]).
//   - Accepts ALU commands {sel, a, b} over a valid/ready handshake.
//   - Buffers them in an in-order FIFO.
//   - Drives them one at a time from registers onto the ALU inputs.
//   - Captures the ALU result one cycle later.
//   - Presents the result, tagged with its opcode, on a valid/ready result port.
//   Sits directly upstream of the ALU, and consumes its output.
//
// PARAMETERS
//   DEPTH  4  command FIFO entries; power of two, >= 2
//   AW     2  FIFO pointer width, = log2(DEPTH)
//
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   cmd_valid  in   1  command present
//   cmd_ready  out  1  FIFO can accept (= !fifo_full)
//   cmd_sel    in   4  ALU opcode
//   cmd_a      in   4  operand a
//   cmd_b      in   4  operand b
//   alu_a      out  4  registered operand a to ALU
//   alu_b      out  4  registered operand b to ALU
//   alu_sel    out  4  registered opcode to ALU
//   alu_y      in   5  ALU result
//   res_valid  out  1  result held
//   res_ready  in   1  consumer takes result
//   res_y      out  5  captured result
//   res_sel    out  4  opcode that produced res_y
//   res_err    out  1  opcode was illegal (sel > 4'b1000)
//
// BEHAVIOUR
//   Reset
//   - rst_n low clears immediately: FIFO pointers and count, FSM -> IDLE,
//     alu_a/alu_b/alu_sel = 0, res_valid/res_y/res_sel/res_err = 0, cmd_ready = 1.
//   - Reset mid-operation discards every in-flight and buffered command. No partial result is output.
//
//   Command push
//   - Push occurs on a clk edge with cmd_valid & cmd_ready.
//   - The FIFO does not pass through: a pop frees a slot from the next cycle only.
//     cmd_ready while full stays 0 even when a pop happens in the same cycle.
//
//   FSM (states IDLE, EXEC, RESP)
//   - IDLE: if FIFO non-empty, pop the head into alu_a/alu_b/alu_sel -> EXEC.
//     Otherwise stay; the ALU registers hold their last values.
//   - EXEC: capture the result and tag it, then -> RESP:
//     res_y <= (alu_sel <= 4'b0001) ? alu_y : {1'b0, alu_y[3:0]};
//     res_sel <= alu_sel;
//     res_err <= (alu_sel > 4'b1000).
//     If res_err = 1, res_y <= 5'b0, so the ALU's z output is never forwarded.
//   - RESP: res_valid = 1; res_y/res_sel/res_err stay stable until the handshake.
//     On res_ready = 1: if FIFO non-empty, pop the next command -> EXEC (back-to-back);
//     otherwise -> IDLE.
//   - res_valid is 1 exactly in RESP.
//
//   Latency and throughput
//   - Command accepted at edge E0 into an empty, idle block:
//     popped at E1, captured at E2, res_valid high from E2.
//   - Sustained throughput is 1 result per 2 cycles with res_ready held high.
//
//   Arithmetic
//   - Bit 4 is meaningful only for sel 0 (carry) and sel 1 (borrow, 5-bit two's complement).
//     For all other opcodes it is forced to 0.
//
//   Ordering
//   - Results come out strictly in command order. No command is dropped or duplicated.
//   - Capacity under backpressure = DEPTH + 1: DEPTH in the FIFO plus one held in EXEC/RESP.
//
// TESTING
//   1. Reset: hold rst_n=0 for 3 cycles, release
//      -> res_valid=0, cmd_ready=1, alu_sel=0, res_y=0.
//   2. Add: cmd {sel=0,a=F,b=1}, res_ready=1
//      -> res_y=5'b10000, res_sel=0, res_err=0; res_valid high 2 edges after acceptance.
//   3. Sub: {sel=1,a=3,b=5} -> res_y=5'b11110.
//      Shift: {sel=8,a=3,b=1} -> res_y=5'b00110.
//   4. Illegal opcode: {sel=4'b1010,a=7,b=2} -> res_err=1, res_y=0, res_sel=4'b1010.
//   5. Backpressure: res_ready=0, offer 7 commands (AND ops, distinct a)
//      -> exactly 5 accepted, then cmd_ready=0.
//      Raise res_ready -> 5 results out in order; the 6th is accepted only after a FIFO pop.
//   6. Reset mid-run: assert rst_n=0 while in EXEC with 3 commands queued
//      -> all outputs at reset values immediately; after release no stale result appears.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_cmd_sequencer : buffers ALU commands, issues them one at a time to the
// combinational ALU and returns each tagged result over a valid/ready port.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [3:0] cmd_sel_i,
  input  logic [3:0] cmd_a_i,
  input  logic [3:0] cmd_b_i,
  output logic [3:0] alu_a_o,
  output logic [3:0] alu_b_o,
  output logic [3:0] alu_sel_o,
  input  logic [4:0] alu_y_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic [4:0] res_y_o,
  output logic [3:0] res_sel_o,
  output logic       res_err_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  logic [11:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic [AW:0]    count_d;
  logic [3:0]     alu_a_q;
  logic [3:0]     alu_b_q;
  logic [3:0]     alu_sel_q;
  logic           res_valid_q;
  logic [4:0]     res_y_q;
  logic [3:0]     res_sel_q;
  logic           res_err_q;

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [11:0]    head;
  logic           illegal;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push    = cmd_valid_i && !full;
  assign pop     = !empty && ((state_q == IDLE) || ((state_q == RESP) && res_ready_i));
  assign head    = mem_q[rd_ptr_q];
  assign illegal = (alu_sel_q > 4'b1000);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_sel_i, cmd_a_i, cmd_b_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_sel_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            {alu_sel_q, alu_a_q, alu_b_q} <= head;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // Illegal opcodes never forward the ALU output; bit 4 only survives add/sub.
          if (illegal) begin
            res_y_q <= '0;
          end else if (alu_sel_q <= 4'b0001) begin
            res_y_q <= alu_y_i;
          end else begin
            res_y_q <= {1'b0, alu_y_i[3:0]};
          end
          res_sel_q   <= alu_sel_q;
          res_err_q   <= illegal;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              {alu_sel_q, alu_a_q, alu_b_q} <= head;
              state_q <= EXEC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = !full;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_sel_o   = alu_sel_q;
  assign res_valid_o = res_valid_q;
  assign res_y_o     = res_y_q;
  assign res_sel_o   = res_sel_q;
  assign res_err_o   = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer : directed and random checks against a queue-based
// reference of the command/result stream, with a behavioural ALU attached.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_sel, cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b, alu_sel;
  logic [4:0] alu_y;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_y;
  logic [3:0] res_sel;
  logic       res_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] last_res;
  logic [9:0] held;
  logic       hold_vld = 1'b0;
  int         n_acc = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_sel_i(cmd_sel), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
    .alu_y_i(alu_y),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_y_o(res_y), .res_sel_o(res_sel), .res_err_o(res_err)
  );

  // Stand-in ALU; several opcodes deliberately set bit 4, and illegal ones drive all ones.
  function automatic logic [4:0] alu_fn(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {1'b0, a} - {1'b0, b};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      4'd5: return {1'b1, ~a};
      4'd6: return {1'b0, a} + 5'd1;
      4'd7: return {1'b0, a} - 5'd1;
      4'd8: return {1'b0, a} << b[1:0];
      default: return 5'b11111;
    endcase
  endfunction

  assign alu_y = alu_fn(alu_sel, alu_a, alu_b);

  // Expected {err, sel, y} for one command.
  function automatic logic [9:0] ref_res(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] y;
    if (s > 4'd8) return {1'b1, s, 5'd0};
    y = alu_fn(s, a, b);
    if (s > 4'd1) y[4] = 1'b0;
    return {1'b0, s, y};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, score the handshakes that will fire at the coming edge.
  task automatic cycle(input logic v, input logic [3:0] s, input logic [3:0] a,
                       input logic [3:0] b, input logic rr);
    logic [9:0] cur;
    cmd_valid = v; cmd_sel = s; cmd_a = a; cmd_b = b; res_ready = rr;
    cur = {res_err, res_sel, res_y};
    if (hold_vld && res_valid) check_eq("hold", 32'(cur), 32'(held));
    if (v && cmd_ready) begin
      exp_q.push_back(ref_res(s, a, b));
      n_acc++;
    end
    if (res_valid && rr) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_res", 32'(cur), 32'h3ff);
      end else begin
        check_eq("res", 32'(cur), 32'(exp_q.pop_front()));
      end
      last_res = cur;
    end
    hold_vld = res_valid && !rr;
    held     = cur;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || res_valid) && k < 60) begin
      cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
      k++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    cycle(1'b1, s, a, b, 1'b1);
    drain();
  endtask

  initial begin
    int idx;
    int acc0;
    int stale;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(res_valid), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    #1;
    check_eq("rel_valid", 32'(res_valid), 32'd0);
    check_eq("rel_ready", 32'(cmd_ready), 32'd1);
    check_eq("rel_alu_sel", 32'(alu_sel), 32'd0);
    check_eq("rel_res_y", 32'(res_y), 32'd0);
    @(posedge clk); #1;

    // Add with carry and first-result latency.
    cycle(1'b1, 4'd0, 4'hF, 4'h1, 1'b1);
    check_eq("lat_e0", 32'(res_valid), 32'd0);
    cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    check_eq("lat_e1", 32'(res_valid), 32'd0);
    check_eq("alu_a_e1", 32'(alu_a), 32'hF);
    cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    check_eq("lat_e2", 32'(res_valid), 32'd1);
    check_eq("add_y", 32'(res_y), 32'h10);
    check_eq("add_sel", 32'(res_sel), 32'd0);
    check_eq("add_err", 32'(res_err), 32'd0);
    drain();

    send(4'd1, 4'd3, 4'd5);
    check_eq("sub", 32'(last_res), 32'({1'b0, 4'd1, 5'b11110}));
    send(4'd8, 4'd3, 4'd1);
    check_eq("shift", 32'(last_res), 32'({1'b0, 4'd8, 5'b00110}));
    send(4'b1010, 4'd7, 4'd2);
    check_eq("illegal", 32'(last_res), 32'({1'b1, 4'b1010, 5'b00000}));
    send(4'd5, 4'd9, 4'd0);
    check_eq("bit4_mask", 32'(last_res), 32'({1'b0, 4'd5, 5'b00110}));

    // Backpressure: offer 7 AND commands with distinct a.
    acc0 = n_acc;
    idx = 0;
    repeat (7) begin
      cycle(1'b1, 4'd2, 4'(idx + 1), 4'hF, 1'b0);
      if (n_acc - acc0 > idx) idx++;
    end
    check_eq("bp_accepted", 32'(n_acc - acc0), 32'd5);
    check_eq("bp_full", 32'(cmd_ready), 32'd0);
    cycle(1'b1, 4'd2, 4'(idx + 1), 4'hF, 1'b1);
    check_eq("bp_no_pass", 32'(n_acc - acc0), 32'd5);
    check_eq("bp_slot_free", 32'(cmd_ready), 32'd1);
    while (idx < 7) begin
      cycle(1'b1, 4'd2, 4'(idx + 1), 4'hF, 1'b1);
      if (n_acc - acc0 > idx) idx++;
    end
    drain();
    check_eq("bp_total", 32'(n_acc - acc0), 32'd7);

    // Reset while a command is in EXEC with three more buffered.
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'd3, 4'(i + 1), 4'd0, 1'b0);
    cycle(1'b1, 4'd3, 4'd5, 4'd0, 1'b0);
    cycle(1'b1, 4'd3, 4'd6, 4'd0, 1'b1);
    check_eq("mid_exec", 32'({res_valid, alu_a}), 32'({1'b0, 4'd2}));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(res_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("mid_rst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
    check_eq("mid_rst_res", 32'({res_err, res_sel, res_y}), 32'd0);
    exp_q.delete();
    hold_vld = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (12) begin
      if (res_valid) stale++;
      cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    end
    check_eq("no_stale", 32'(stale), 32'd0);

    // Random traffic against the reference queue.
    repeat (400) begin
      cycle(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
            4'($urandom_range(15, 0)), 1'($urandom_range(3, 0) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
